// File: rtl/chain_pkg.sv
// Shared types for the DP-chaining predecessor scanner: anchor history
// records, in-flight score tags, FSM states and the eligibility test.
package chain_pkg;

   localparam int SCORE_W     = 32;
   localparam int POS_W       = 32;
   localparam int CHAIN_IDX_W = 16;

   // One stored anchor: its positions and its final chain score
   typedef struct packed {
      logic [POS_W-1:0]          rx;
      logic [POS_W-1:0]          qx;
      logic signed [SCORE_W-1:0] f;
   } anchor_t;

   // Travels alongside a pair so the returning score can be attributed
   typedef struct packed {
      logic                      valid;
      logic                      elig;
      logic [CHAIN_IDX_W-1:0]    j;
      logic signed [SCORE_W-1:0] f;
   } tag_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      EMIT  = 2'd3
   } state_t;

   // j may precede i only if it lies strictly before i on both axes and
   // within max_dist on both axes; all compares are unsigned
   function automatic logic is_eligible(input logic [POS_W-1:0] rx_i,
                                        input logic [POS_W-1:0] qx_i,
                                        input logic [POS_W-1:0] rx_j,
                                        input logic [POS_W-1:0] qx_j,
                                        input logic [POS_W-1:0] max_dist);
      return (rx_j < rx_i) && (qx_j < qx_i) &&
             ((rx_i - rx_j) <= max_dist) && ((qx_i - qx_j) <= max_dist);
   endfunction

endpackage

// File: rtl/chain_hist_buf.sv
// Ring of the most recent anchors, indexed by anchor index mod DEPTH.
// One synchronous write port, one combinational read port.
module chain_hist_buf
   import chain_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  anchor_t       wr_data,
   input  logic [AW-1:0] rd_addr,
   output anchor_t       rd_data
);

   anchor_t mem [DEPTH];

   // Store a finished anchor; contents need no reset since validity is
   // tracked by the scanner's fill count
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/chain_pred_scanner.sv
// Issues (i, j) anchor pairs to the fixed-latency scorer, nearest j first,
// and folds the returned scores into f(i) and its best predecessor.
module chain_pred_scanner
   import chain_pkg::*;
#(
   parameter int DEPTH     = 64,
   parameter int SCORE_LAT = 4,
   parameter int MAX_DIST  = 5000,
   parameter int IDX_W     = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_rx,
   input  logic [31:0]      in_qx,
   input  logic [31:0]      in_w,
   input  logic             in_last,
   output logic             sc_valid,
   output logic [31:0]      sc_rx,
   output logic [31:0]      sc_ry,
   output logic [31:0]      sc_qx,
   output logic [31:0]      sc_qy,
   output logic [31:0]      sc_w,
   input  logic [31:0]      sc_score,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_f,
   output logic [IDX_W-1:0] out_p,
   output logic             out_has_p,
   output logic [IDX_W-1:0] out_idx
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int DR_W  = $clog2(SCORE_LAT + 1);

   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
   localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(SCORE_LAT - 1);
   localparam logic [31:0]      MAX_DIST_C = 32'(MAX_DIST);

   state_t                    state;
   logic [IDX_W-1:0]          idx_cnt;
   logic [CNT_W-1:0]          fill_cnt;
   logic [31:0]               rx_i;
   logic [31:0]               qx_i;
   logic [31:0]               w_i;
   logic                      last_i;
   logic [IDX_W-1:0]          i_idx;
   logic [CNT_W-1:0]          n;
   logic [CNT_W-1:0]          k;
   logic [DR_W-1:0]           drain_cnt;
   logic signed [SCORE_W-1:0] best;
   logic [IDX_W-1:0]          p;
   logic                      has_p;
   tag_t                      sc_tag;
   tag_t                      tag_pipe [SCORE_LAT];

   logic [31:0]               cur_rx;
   logic [31:0]               cur_qx;
   logic [31:0]               cur_w;
   logic [CNT_W-1:0]          next_off;
   logic [IDX_W-1:0]          base_idx;
   logic [IDX_W-1:0]          rd_idx;
   logic                      pair_elig;
   logic                      issue_now;
   tag_t                      tail;
   logic signed [SCORE_W-1:0] cand;
   logic                      take;
   logic                      hist_we;
   anchor_t                   hist_wr;
   anchor_t                   hist_rd;

   chain_hist_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_hist (
      .clk     (clk),
      .wr_en   (hist_we),
      .wr_addr (i_idx[AW-1:0]),
      .wr_data (hist_wr),
      .rd_addr (rd_idx[AW-1:0]),
      .rd_data (hist_rd)
   );

   // Pair selection: on accept the anchor comes straight from the inputs
   // and j = i-1; while issuing, look ahead to j = i-(k+1)
   always_comb begin
      cur_rx    = (state == IDLE) ? in_rx : rx_i;
      cur_qx    = (state == IDLE) ? in_qx : qx_i;
      cur_w     = (state == IDLE) ? in_w  : w_i;
      next_off  = (state == IDLE) ? CNT_W'(1) : k + CNT_W'(1);
      base_idx  = (state == IDLE) ? idx_cnt : i_idx;
      rd_idx    = base_idx - IDX_W'(next_off);
      pair_elig = is_eligible(cur_rx, cur_qx, hist_rd.rx, hist_rd.qx, MAX_DIST_C);
      issue_now = ((state == IDLE) && in_valid && (fill_cnt != '0)) ||
                  ((state == ISSUE) && (k != n));
      tail      = tag_pipe[SCORE_LAT-1];
      cand      = $signed(tail.f) + $signed(sc_score);
      take      = ((state == ISSUE) || (state == DRAIN)) &&
                  tail.valid && tail.elig && (cand > best);
      hist_we   = (state == EMIT) && out_ready;
      hist_wr   = '{rx: rx_i, qx: qx_i, f: best};
   end

   // Main control: anchor latch, pair counting, score folding, bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         idx_cnt   <= '0;
         fill_cnt  <= '0;
         rx_i      <= '0;
         qx_i      <= '0;
         w_i       <= '0;
         last_i    <= 1'b0;
         i_idx     <= '0;
         n         <= '0;
         k         <= '0;
         drain_cnt <= '0;
         best      <= '0;
         p         <= '0;
         has_p     <= 1'b0;
      end else begin
         if (take) begin
            best  <= cand;
            p     <= IDX_W'(tail.j);
            has_p <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (in_valid) begin
                  rx_i   <= in_rx;
                  qx_i   <= in_qx;
                  w_i    <= in_w;
                  last_i <= in_last;
                  i_idx  <= idx_cnt;
                  n      <= fill_cnt;
                  k      <= CNT_W'(1);
                  best   <= $signed(in_w);
                  p      <= '0;
                  has_p  <= 1'b0;
                  state  <= (fill_cnt != '0) ? ISSUE : EMIT;
               end
            end
            ISSUE: begin
               if (k == n) begin
                  drain_cnt <= '0;
                  state     <= DRAIN;
               end else begin
                  k <= k + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state <= EMIT;
               end else begin
                  drain_cnt <= drain_cnt + DR_W'(1);
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (last_i) begin
                     idx_cnt  <= '0;
                     fill_cnt <= '0;
                  end else begin
                     idx_cnt <= idx_cnt + IDX_W'(1);
                     if (fill_cnt != DEPTH_C) begin
                        fill_cnt <= fill_cnt + CNT_W'(1);
                     end
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Registered scorer drive plus the tag that shadows the pair on the bus
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sc_valid <= 1'b0;
         sc_rx    <= '0;
         sc_ry    <= '0;
         sc_qx    <= '0;
         sc_qy    <= '0;
         sc_w     <= '0;
         sc_tag   <= '0;
      end else if (issue_now) begin
         sc_valid <= 1'b1;
         sc_rx    <= cur_rx;
         sc_ry    <= hist_rd.rx;
         sc_qx    <= cur_qx;
         sc_qy    <= hist_rd.qx;
         sc_w     <= cur_w;
         sc_tag   <= '{valid: 1'b1, elig: pair_elig,
                       j: CHAIN_IDX_W'(rd_idx), f: hist_rd.f};
      end else begin
         sc_valid <= 1'b0;
         sc_rx    <= '0;
         sc_ry    <= '0;
         sc_qx    <= '0;
         sc_qy    <= '0;
         sc_w     <= '0;
         sc_tag   <= '0;
      end
   end

   // Delay tags to line up with the scorer result arriving SCORE_LAT later
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SCORE_LAT; s++) begin
            tag_pipe[s] <= '0;
         end
      end else begin
         tag_pipe[0] <= sc_tag;
         for (int s = 1; s < SCORE_LAT; s++) begin
            tag_pipe[s] <= tag_pipe[s-1];
         end
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == EMIT);
   assign out_f     = best;
   assign out_p     = p;
   assign out_has_p = has_p;
   assign out_idx   = i_idx;

endmodule
